// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colour types and palette for the box renderer
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Index 0 is the low slice: red, green, blue, white
    localparam logic [3:0][11:0] PALETTE = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
    localparam rgb_t BACKGROUND = 12'h004;
    localparam rgb_t BLACK      = 12'h000;

    function automatic rgb_t palette_lookup(input logic [1:0] idx);
        return rgb_t'(PALETTE[idx]);
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// rtl/vga_box_mover.sv - frame tick detection, box motion, colour index and bounce counter
module vga_box_mover #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 2,
    parameter int XW        = $clog2(640) + 1,
    parameter int YW        = $clog2(480) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          vsync_i,
    input  logic          pause_i,
    output logic [XW-1:0] box_x,
    output logic [YW-1:0] box_y,
    output logic [1:0]    color_idx,
    output logic [7:0]    bounce_count
);

    localparam logic [XW-1:0] X_LIM   = XW'(H_VISIBLE);
    localparam logic [XW-1:0] X_MAX   = XW'(H_VISIBLE - BOX_SIZE);
    localparam logic [XW-1:0] X_RESET = XW'((H_VISIBLE - BOX_SIZE) / 2);
    localparam logic [XW-1:0] X_REACH = XW'(BOX_SIZE + STEP);
    localparam logic [XW-1:0] X_STEP  = XW'(STEP);
    localparam logic [YW-1:0] Y_LIM   = YW'(V_VISIBLE);
    localparam logic [YW-1:0] Y_MAX   = YW'(V_VISIBLE - BOX_SIZE);
    localparam logic [YW-1:0] Y_RESET = YW'((V_VISIBLE - BOX_SIZE) / 2);
    localparam logic [YW-1:0] Y_REACH = YW'(BOX_SIZE + STEP);
    localparam logic [YW-1:0] Y_STEP  = YW'(STEP);

    logic          vsync_q;
    logic          dir_right;
    logic          dir_down;
    logic          tick;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic          dir_right_next;
    logic          dir_down_next;
    logic          bounce_x;
    logic          bounce_y;

    assign tick = vsync_q & ~vsync_i;

    always_comb begin
        x_next         = box_x;
        dir_right_next = dir_right;
        bounce_x       = 1'b0;
        if (dir_right) begin
            if (box_x + X_REACH > X_LIM) begin
                x_next         = X_MAX;
                dir_right_next = 1'b0;
                bounce_x       = 1'b1;
            end else begin
                x_next = box_x + X_STEP;
            end
        end else begin
            if (box_x < X_STEP) begin
                x_next         = '0;
                dir_right_next = 1'b1;
                bounce_x       = 1'b1;
            end else begin
                x_next = box_x - X_STEP;
            end
        end
    end

    always_comb begin
        y_next        = box_y;
        dir_down_next = dir_down;
        bounce_y      = 1'b0;
        if (dir_down) begin
            if (box_y + Y_REACH > Y_LIM) begin
                y_next        = Y_MAX;
                dir_down_next = 1'b0;
                bounce_y      = 1'b1;
            end else begin
                y_next = box_y + Y_STEP;
            end
        end else begin
            if (box_y < Y_STEP) begin
                y_next        = '0;
                dir_down_next = 1'b1;
                bounce_y      = 1'b1;
            end else begin
                y_next = box_y - Y_STEP;
            end
        end
    end

    // A corner hit bounces both axes but still counts once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsync_q      <= 1'b1;
            box_x        <= X_RESET;
            box_y        <= Y_RESET;
            dir_right    <= 1'b1;
            dir_down     <= 1'b1;
            color_idx    <= 2'd0;
            bounce_count <= 8'd0;
        end else begin
            vsync_q <= vsync_i;
            if (tick && !pause_i) begin
                box_x     <= x_next;
                box_y     <= y_next;
                dir_right <= dir_right_next;
                dir_down  <= dir_down_next;
                if (bounce_x || bounce_y) begin
                    color_idx    <= color_idx + 2'd1;
                    bounce_count <= bounce_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_box_renderer.sv
// rtl/vga_box_renderer.sv - two-stage pixel pipeline drawing a bouncing box over a background
module vga_box_renderer
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int BOX_SIZE  = 32,
    parameter int STEP      = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         hsync_i,
    input  logic                         vsync_i,
    input  logic                         visible_i,
    input  logic [$clog2(H_VISIBLE)-1:0] position_x_i,
    input  logic [$clog2(V_VISIBLE)-1:0] position_y_i,
    input  logic                         pause_i,
    output logic [3:0]                   red_o,
    output logic [3:0]                   green_o,
    output logic [3:0]                   blue_o,
    output logic                         hsync_o,
    output logic                         vsync_o,
    output logic [7:0]                   bounce_count_o
);

    localparam int XW = $clog2(H_VISIBLE) + 1;
    localparam int YW = $clog2(V_VISIBLE) + 1;
    localparam logic [XW-1:0] X_SIZE = XW'(BOX_SIZE);
    localparam logic [YW-1:0] Y_SIZE = YW'(BOX_SIZE);

    logic [XW-1:0] box_x;
    logic [YW-1:0] box_y;
    logic [1:0]    color_idx;
    logic [XW-1:0] x_ext;
    logic [YW-1:0] y_ext;
    logic          inside_c;

    logic          vis_s1;
    logic          hs_s1;
    logic          vs_s1;
    logic          inside_s1;
    logic          hs_s2;
    logic          vs_s2;
    rgb_t          pix_s2;

    vga_box_mover #(
        .H_VISIBLE (H_VISIBLE),
        .V_VISIBLE (V_VISIBLE),
        .BOX_SIZE  (BOX_SIZE),
        .STEP      (STEP),
        .XW        (XW),
        .YW        (YW)
    ) u_mover (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .vsync_i      (vsync_i),
        .pause_i      (pause_i),
        .box_x        (box_x),
        .box_y        (box_y),
        .color_idx    (color_idx),
        .bounce_count (bounce_count_o)
    );

    assign x_ext    = {1'b0, position_x_i};
    assign y_ext    = {1'b0, position_y_i};
    assign inside_c = (x_ext >= box_x) && (x_ext < box_x + X_SIZE) &&
                      (y_ext >= box_y) && (y_ext < box_y + Y_SIZE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vis_s1    <= 1'b0;
            hs_s1     <= 1'b1;
            vs_s1     <= 1'b1;
            inside_s1 <= 1'b0;
            hs_s2     <= 1'b1;
            vs_s2     <= 1'b1;
            pix_s2    <= BLACK;
        end else begin
            vis_s1    <= visible_i;
            hs_s1     <= hsync_i;
            vs_s1     <= vsync_i;
            inside_s1 <= inside_c;
            hs_s2     <= hs_s1;
            vs_s2     <= vs_s1;
            if (!vis_s1) begin
                pix_s2 <= BLACK;
            end else if (inside_s1) begin
                pix_s2 <= palette_lookup(color_idx);
            end else begin
                pix_s2 <= BACKGROUND;
            end
        end
    end

    assign red_o   = pix_s2.r;
    assign green_o = pix_s2.g;
    assign blue_o  = pix_s2.b;
    assign hsync_o = hs_s2;
    assign vsync_o = vs_s2;

endmodule

// File: tb/tb_vga_box_renderer.sv
// tb/tb_vga_box_renderer.sv - directed self-checking bench for vga_box_renderer
module tb_vga_box_renderer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hsync_i;
    logic       vsync_i;
    logic       visible_i;
    logic [9:0] px;
    logic [8:0] py;
    logic       pause_i;
    logic [3:0] red, green, blue;
    logic       hsync_o, vsync_o;
    logic [7:0] bounce;

    logic [3:0] sq_red, sq_green, sq_blue;
    logic       sq_hsync, sq_vsync;
    logic [7:0] sq_bounce;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    always #5 clk = ~clk;

    vga_box_renderer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .hsync_i        (hsync_i),
        .vsync_i        (vsync_i),
        .visible_i      (visible_i),
        .position_x_i   (px),
        .position_y_i   (py),
        .pause_i        (pause_i),
        .red_o          (red),
        .green_o        (green),
        .blue_o         (blue),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .bounce_count_o (bounce)
    );

    // Small square screen so a true corner bounce happens within a few dozen frames
    vga_box_renderer #(
        .H_VISIBLE (64),
        .V_VISIBLE (64),
        .BOX_SIZE  (16),
        .STEP      (2)
    ) dut_sq (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .hsync_i        (hsync_i),
        .vsync_i        (vsync_i),
        .visible_i      (visible_i),
        .position_x_i   (px[5:0]),
        .position_y_i   (py[5:0]),
        .pause_i        (pause_i),
        .red_o          (sq_red),
        .green_o        (sq_green),
        .blue_o         (sq_blue),
        .hsync_o        (sq_hsync),
        .vsync_o        (sq_vsync),
        .bounce_count_o (sq_bounce)
    );

    function automatic logic [11:0] rgb();
        return {red, green, blue};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_tick();
        @(negedge clk);
        vsync_i = 1'b0;
        @(negedge clk);
        vsync_i = 1'b1;
        @(negedge clk);
        ticks++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        hsync_i = 1'b1; vsync_i = 1'b1; visible_i = 1'b0; pause_i = 1'b0;
        px = '0; py = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ticks = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (rgb() !== 12'h000) begin errors++; $display("FAIL reset_rgb actual=%h required=000", rgb()); end
        checks++;
        if (hsync_o !== 1'b1 || vsync_o !== 1'b1) begin
            errors++; $display("FAIL reset_sync actual=%b%b required=11", hsync_o, vsync_o);
        end
        chk("reset_bounce", int'(bounce), 0);
        chk("reset_box_x", int'(dut.u_mover.box_x), 304);
        chk("reset_box_y", int'(dut.u_mover.box_y), 224);
    endtask

    task automatic test_pixels();
        @(negedge clk);
        px = 10'd304; py = 9'd224; visible_i = 1'b1;
        @(negedge clk);
        px = 10'd303;
        @(negedge clk);
        checks++;
        if (rgb() !== 12'hF00) begin errors++; $display("FAIL pix_inside actual=%h required=F00", rgb()); end
        px = 10'd304; visible_i = 1'b0;
        @(negedge clk);
        checks++;
        if (rgb() !== 12'h004) begin errors++; $display("FAIL pix_left_edge actual=%h required=004", rgb()); end
        px = 10'd335; visible_i = 1'b1;
        @(negedge clk);
        checks++;
        if (rgb() !== 12'h000) begin errors++; $display("FAIL pix_blank actual=%h required=000", rgb()); end
        px = 10'd336;
        @(negedge clk);
        checks++;
        if (rgb() !== 12'hF00) begin errors++; $display("FAIL pix_right_last actual=%h required=F00", rgb()); end
        visible_i = 1'b0;
        @(negedge clk);
        checks++;
        if (rgb() !== 12'h004) begin errors++; $display("FAIL pix_right_out actual=%h required=004", rgb()); end
    endtask

    task automatic test_sync_delay();
        logic [9:0] hp;
        logic [9:0] vp;
        hp = 10'b1011001101;
        vp = 10'b1101110011;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (hsync_o !== hp[i-2] || vsync_o !== vp[i-2]) begin
                    errors++;
                    $display("FAIL sync_delay[%0d] actual=%b%b required=%b%b", i, hsync_o, vsync_o, hp[i-2], vp[i-2]);
                end
            end
            hsync_i = hp[i];
            vsync_i = vp[i];
        end
        @(negedge clk);
        hsync_i = 1'b1; vsync_i = 1'b1;
    endtask

    task automatic test_motion();
        apply_reset();
        while (ticks < 153) begin
            do_tick();
            case (ticks)
                1: begin
                    chk("t1_x", int'(dut.u_mover.box_x), 306);
                    chk("t1_y", int'(dut.u_mover.box_y), 226);
                end
                12: begin
                    chk("t12_x", int'(dut.u_mover.box_x), 328);
                    chk("sq_t12_x", int'(dut_sq.u_mover.box_x), 48);
                end
                13: begin
                    chk("sq_corner_x", int'(dut_sq.u_mover.box_x), 48);
                    chk("sq_corner_y", int'(dut_sq.u_mover.box_y), 48);
                    chk("sq_corner_dirs", int'({dut_sq.u_mover.dir_right, dut_sq.u_mover.dir_down}), 0);
                    chk("sq_corner_count", int'(sq_bounce), 1);
                end
                37: begin
                    chk("sq_t37_x", int'(dut_sq.u_mover.box_x), 0);
                    chk("sq_t37_y", int'(dut_sq.u_mover.box_y), 0);
                end
                38: begin
                    chk("sq_origin_x", int'(dut_sq.u_mover.box_x), 0);
                    chk("sq_origin_y", int'(dut_sq.u_mover.box_y), 0);
                    chk("sq_origin_dirs", int'({dut_sq.u_mover.dir_right, dut_sq.u_mover.dir_down}), 3);
                    chk("sq_origin_count", int'(sq_bounce), 2);
                end
                112: begin
                    chk("t112_y", int'(dut.u_mover.box_y), 448);
                    chk("t112_count", int'(bounce), 0);
                end
                113: begin
                    chk("ybounce_y", int'(dut.u_mover.box_y), 448);
                    chk("ybounce_dir", int'(dut.u_mover.dir_down), 0);
                    chk("ybounce_color", int'(dut.u_mover.color_idx), 1);
                    chk("ybounce_count", int'(bounce), 1);
                end
                151: chk("t151_x", int'(dut.u_mover.box_x), 606);
                152: begin
                    chk("t152_x", int'(dut.u_mover.box_x), 608);
                    chk("t152_dir", int'(dut.u_mover.dir_right), 1);
                    chk("t152_y", int'(dut.u_mover.box_y), 370);
                end
                153: begin
                    chk("xbounce_x", int'(dut.u_mover.box_x), 608);
                    chk("xbounce_dir", int'(dut.u_mover.dir_right), 0);
                    chk("xbounce_color", int'(dut.u_mover.color_idx), 2);
                    chk("xbounce_count", int'(bounce), 2);
                    chk("xbounce_y", int'(dut.u_mover.box_y), 368);
                end
                default: ;
            endcase
        end
        @(negedge clk);
        px = 10'd608; py = 9'd368; visible_i = 1'b1;
        @(negedge clk);
        px = 10'd607;
        @(negedge clk);
        checks++;
        if (rgb() !== 12'h00F) begin errors++; $display("FAIL pix_color2 actual=%h required=00F", rgb()); end
        visible_i = 1'b0;
        @(negedge clk);
        checks++;
        if (rgb() !== 12'h004) begin errors++; $display("FAIL pix_color2_out actual=%h required=004", rgb()); end
    endtask

    task automatic test_pause();
        pause_i = 1'b1;
        repeat (3) do_tick();
        chk("pause_x", int'(dut.u_mover.box_x), 608);
        chk("pause_y", int'(dut.u_mover.box_y), 368);
        chk("pause_color", int'(dut.u_mover.color_idx), 2);
        chk("pause_count", int'(bounce), 2);
        pause_i = 1'b0;
        do_tick();
        chk("resume_x", int'(dut.u_mover.box_x), 606);
        chk("resume_y", int'(dut.u_mover.box_y), 366);
        chk("resume_count", int'(bounce), 2);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        px = 10'd606; py = 9'd366; visible_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (rgb() !== 12'h00F || hsync_o !== 1'b0) begin
            errors++; $display("FAIL prereset_state actual=%h/%b required=00F/0", rgb(), hsync_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rgb() !== 12'h000 || hsync_o !== 1'b1 || vsync_o !== 1'b1 || bounce !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_outputs actual=%h/%b%b/%0d required=000/11/0", rgb(), hsync_o, vsync_o, bounce);
        end
        chk("async_reset_x", int'(dut.u_mover.box_x), 304);
        chk("async_reset_y", int'(dut.u_mover.box_y), 224);
        @(negedge clk);
        hsync_i = 1'b1; visible_i = 1'b1; px = 10'd304; py = 9'd224;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rgb() !== 12'h000) begin errors++; $display("FAIL release_cycle1 actual=%h required=000", rgb()); end
        @(negedge clk);
        checks++;
        if (rgb() !== 12'hF00) begin errors++; $display("FAIL release_cycle2 actual=%h required=F00", rgb()); end
    endtask

    initial begin
        rst_n = 1'b0;
        hsync_i = 1'b1; vsync_i = 1'b1; visible_i = 1'b0; pause_i = 1'b0;
        px = '0; py = '0;
        test_reset();
        test_pixels();
        test_sync_delay();
        test_motion();
        test_pause();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
